// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   Architectural register file with a per-register busy (scoreboard) bit.
//   Two combinational read ports return operand data and a busy flag. Both
//   include a same-cycle write-back bypass. A reservation port marks a
//   destination busy at issue. It stalls (oRSV_READY=0) on a write-after-write
//   hazard unless the pending write-back lands in the same cycle. A write-back
//   port stores ALU results and clears busy bits.
//
// Ports
//   iCLK                    clock, rising edge
//   iRST_N                  asynchronous active-low reset
//   iRS1 / iRS2             read indices
//   oRS1_DATA / oRS2_DATA   operand values (bypassed from write-back)
//   oRS1_BUSY / oRS2_BUSY   operand not yet available
//   iRSV_VALID / iRSV_RD    destination reservation request
//   oRSV_READY              reservation accepted this cycle
//   iWB_VALID / iWB_RD / iWB_DATA   write-back
//   oPENDING                number of busy registers
//   oERR                    sticky flag: write-back to a non-busy register
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic [4:0]      iRS1,
  input  logic [4:0]      iRS2,
  output logic [XLEN-1:0] oRS1_DATA,
  output logic [XLEN-1:0] oRS2_DATA,
  output logic            oRS1_BUSY,
  output logic            oRS2_BUSY,
  input  logic            iRSV_VALID,
  input  logic [4:0]      iRSV_RD,
  output logic            oRSV_READY,
  input  logic            iWB_VALID,
  input  logic [4:0]      iWB_RD,
  input  logic [XLEN-1:0] iWB_DATA,
  output logic [5:0]      oPENDING,
  output logic            oERR
);

  localparam int IW = 5;

  logic [XLEN-1:0] rf_rd [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [5:0]      pending_q, pending_d;
  logic            err_q, err_d;

  logic wb_en;
  logic rsv_en;
  logic rs1_hit, rs2_hit, rsv_hit;

  // A write-back to x0 is architecturally a no-op.
  assign wb_en = iWB_VALID && (iWB_RD != '0);

  // Match terms against the raw write-back index. For x0 the busy bit is
  // always clear, so matching rd=0 is harmless for busy and ready. The data
  // bypass uses wb_en so that x0 keeps reading zero.
  assign rs1_hit = iWB_VALID && (iWB_RD == iRS1);
  assign rs2_hit = iWB_VALID && (iWB_RD == iRS2);
  assign rsv_hit = iWB_VALID && (iWB_RD == iRSV_RD);

  // ---------------------------------------------------------------------------
  // Storage: one register per architectural index. x0 is hard-wired to zero.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign rf_rd[gi] = '0;
      end else begin : g_live
        logic [XLEN-1:0] data_q;
        always_ff @(posedge iCLK or negedge iRST_N) begin
          if (!iRST_N) begin
            data_q <= '0;
          end else if (wb_en && (iWB_RD == IW'(gi))) begin
            data_q <= iWB_DATA;
          end
        end
        assign rf_rd[gi] = data_q;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read ports (zero latency, write-back bypass)
  // ---------------------------------------------------------------------------
  assign oRS1_DATA = (wb_en && rs1_hit) ? iWB_DATA : rf_rd[iRS1];
  assign oRS2_DATA = (wb_en && rs2_hit) ? iWB_DATA : rf_rd[iRS2];
  assign oRS1_BUSY = busy_q[iRS1] && !rs1_hit;
  assign oRS2_BUSY = busy_q[iRS2] && !rs2_hit;

  // ---------------------------------------------------------------------------
  // Reservation handshake: stall only on a WAW hazard that is not being
  // resolved by a write-back in this same cycle.
  // ---------------------------------------------------------------------------
  assign oRSV_READY = iRSV_VALID &&
                      ((iRSV_RD == '0) || !busy_q[iRSV_RD] || rsv_hit);
  assign rsv_en     = oRSV_READY && (iRSV_RD != '0);

  // ---------------------------------------------------------------------------
  // Next-state scoreboard. The clear from write-back is applied before the
  // set from reservation. When both target the same rd, the register
  // therefore stays busy for the new producer.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (wb_en) begin
      if (!busy_q[iWB_RD]) begin
        err_d = 1'b1;
      end
      busy_d[iWB_RD] = 1'b0;
    end
    if (rsv_en) begin
      busy_d[iRSV_RD] = 1'b1;
    end
    // Pending is derived from the busy vector itself, so it cannot drift
    // or wrap.
    pending_d = '0;
    for (int i = 0; i < NREG; i++) begin
      pending_d = pending_d + {5'b0, busy_d[i]};
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      busy_q    <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign oPENDING = pending_q;
  assign oERR     = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//   Self-checking bench for regfile_scoreboard. The reference model is a plain
//   array of register values plus a busy flag per register. It is updated once
//   per clock from the register-file rules.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [4:0]  iRS1, iRS2;
  logic [31:0] oRS1_DATA, oRS2_DATA;
  logic        oRS1_BUSY, oRS2_BUSY;
  logic        iRSV_VALID;
  logic [4:0]  iRSV_RD;
  logic        oRSV_READY;
  logic        iWB_VALID;
  logic [4:0]  iWB_RD;
  logic [31:0] iWB_DATA;
  logic [5:0]  oPENDING;
  logic        oERR;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  logic [31:0] m_reg  [32];
  bit          m_busy [32];
  bit          m_err;

  regfile_scoreboard #(.XLEN(32), .NREG(32)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iRS1(iRS1), .iRS2(iRS2),
    .oRS1_DATA(oRS1_DATA), .oRS2_DATA(oRS2_DATA),
    .oRS1_BUSY(oRS1_BUSY), .oRS2_BUSY(oRS2_BUSY),
    .iRSV_VALID(iRSV_VALID), .iRSV_RD(iRSV_RD), .oRSV_READY(oRSV_READY),
    .iWB_VALID(iWB_VALID), .iWB_RD(iWB_RD), .iWB_DATA(iWB_DATA),
    .oPENDING(oPENDING), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  // ---------------- model helpers (expectations only) ----------------
  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  function automatic logic [5:0] m_pending();
    int c = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) c++;
    return 6'(c);
  endfunction

  function automatic logic [31:0] m_data(input logic [4:0] rs);
    if (rs == 0) return 32'h0;
    if (iWB_VALID && iWB_RD == rs) return iWB_DATA;
    return m_reg[rs];
  endfunction

  function automatic bit m_bsy(input logic [4:0] rs);
    return m_busy[rs] && !(iWB_VALID && iWB_RD == rs);
  endfunction

  function automatic bit m_ready();
    if (!iRSV_VALID) return 1'b0;
    if (iRSV_RD == 0) return 1'b1;
    if (!m_busy[iRSV_RD]) return 1'b1;
    return iWB_VALID && iWB_RD == iRSV_RD;
  endfunction

  task automatic idle();
    iRSV_VALID = 1'b0; iRSV_RD = '0;
    iWB_VALID  = 1'b0; iWB_RD  = '0; iWB_DATA = '0;
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    bit rdy;
    rdy = m_ready();
    @(posedge iCLK);
    if (iWB_VALID && iWB_RD != 0) begin
      if (!m_busy[iWB_RD]) m_err = 1'b1;
      m_reg[iWB_RD]  = iWB_DATA;
      m_busy[iWB_RD] = 1'b0;
    end
    if (rdy && iRSV_RD != 0) m_busy[iRSV_RD] = 1'b1;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    iRST_N = 1'b0;
    iRS1 = 5'd5; iRS2 = 5'd0;
    idle();
    model_reset();
    #12;
    n_checks++; if (oRS1_DATA !== 32'h0) $display("FAIL reset_rs1_data got %h want 0", oRS1_DATA); else n_pass++;
    n_checks++; if (oRS2_DATA !== 32'h0) $display("FAIL reset_rs2_data got %h want 0", oRS2_DATA); else n_pass++;
    n_checks++; if (oRS1_BUSY !== 1'b0 || oRS2_BUSY !== 1'b0) $display("FAIL reset_busy got %b%b want 00", oRS1_BUSY, oRS2_BUSY); else n_pass++;
    n_checks++; if (oPENDING !== 6'd0) $display("FAIL reset_pending got %0d want 0", oPENDING); else n_pass++;
    n_checks++; if (oERR !== 1'b0) $display("FAIL reset_err got %b want 0", oERR); else n_pass++;
    $display("txn reset: rs1=5 rs2=0 data=%h/%h pending=%0d err=%b", oRS1_DATA, oRS2_DATA, oPENDING, oERR);
    iRST_N = 1'b1;
  endtask

  task automatic test_reserve_bypass();
    idle(); iRSV_VALID = 1'b1; iRSV_RD = 5'd3;
    #1;
    n_checks++; if (oRSV_READY !== 1'b1) $display("FAIL rsv3_ready got %b want 1", oRSV_READY); else n_pass++;
    tick();
    idle(); iRS1 = 5'd3;
    #1;
    n_checks++; if (oRS1_BUSY !== 1'b1) $display("FAIL rsv3_busy got %b want 1", oRS1_BUSY); else n_pass++;
    n_checks++; if (oPENDING !== 6'd1) $display("FAIL rsv3_pending got %0d want 1", oPENDING); else n_pass++;
    iWB_VALID = 1'b1; iWB_RD = 5'd3; iWB_DATA = 32'h0000_00AB;
    #1;
    n_checks++; if (oRS1_BUSY !== 1'b0) $display("FAIL bypass_busy got %b want 0", oRS1_BUSY); else n_pass++;
    n_checks++; if (oRS1_DATA !== 32'hAB) $display("FAIL bypass_data got %h want 000000ab", oRS1_DATA); else n_pass++;
    tick();
    idle();
    #1;
    n_checks++; if (oPENDING !== 6'd0) $display("FAIL wb3_pending got %0d want 0", oPENDING); else n_pass++;
    n_checks++; if (oRS1_DATA !== 32'hAB) $display("FAIL wb3_stored got %h want 000000ab", oRS1_DATA); else n_pass++;
    n_checks++; if (oERR !== 1'b0) $display("FAIL wb3_err got %b want 0", oERR); else n_pass++;
    $display("txn reserve/bypass rd=3: stored=%h pending=%0d", oRS1_DATA, oPENDING);
  endtask

  task automatic test_waw();
    idle(); iRSV_VALID = 1'b1; iRSV_RD = 5'd7;
    tick();
    #1;
    n_checks++; if (oRSV_READY !== 1'b0) $display("FAIL waw_stall got %b want 0", oRSV_READY); else n_pass++;
    iWB_VALID = 1'b1; iWB_RD = 5'd7; iWB_DATA = 32'h1234;
    #1;
    n_checks++; if (oRSV_READY !== 1'b1) $display("FAIL waw_release got %b want 1", oRSV_READY); else n_pass++;
    tick();
    idle(); iRS1 = 5'd7;
    #1;
    n_checks++; if (oRS1_BUSY !== 1'b1) $display("FAIL waw_busy got %b want 1", oRS1_BUSY); else n_pass++;
    n_checks++; if (oPENDING !== 6'd1) $display("FAIL waw_pending got %0d want 1", oPENDING); else n_pass++;
    n_checks++; if (oRS1_DATA !== 32'h1234) $display("FAIL waw_stored got %h want 00001234", oRS1_DATA); else n_pass++;
    $display("txn waw rd=7: busy=%b pending=%0d data=%h", oRS1_BUSY, oPENDING, oRS1_DATA);
  endtask

  task automatic test_x0();
    idle(); iWB_VALID = 1'b1; iWB_RD = 5'd0; iWB_DATA = 32'hFFFF_FFFF; iRS1 = 5'd0;
    #1;
    n_checks++; if (oRS1_DATA !== 32'h0) $display("FAIL x0_bypass got %h want 0", oRS1_DATA); else n_pass++;
    tick();
    idle();
    #1;
    n_checks++; if (oRS1_DATA !== 32'h0) $display("FAIL x0_stored got %h want 0", oRS1_DATA); else n_pass++;
    n_checks++; if (oERR !== 1'b0) $display("FAIL x0_err got %b want 0", oERR); else n_pass++;
    $display("txn x0 write: x0=%h err=%b", oRS1_DATA, oERR);
  endtask

  task automatic test_err();
    idle(); iWB_VALID = 1'b1; iWB_RD = 5'd9; iWB_DATA = 32'h55;
    tick();
    idle(); iRS2 = 5'd9;
    #1;
    n_checks++; if (oERR !== 1'b1) $display("FAIL err_set got %b want 1", oERR); else n_pass++;
    n_checks++; if (oRS2_DATA !== 32'h55) $display("FAIL err_reg9 got %h want 00000055", oRS2_DATA); else n_pass++;
    tick(); tick();
    n_checks++; if (oERR !== 1'b1) $display("FAIL err_sticky got %b want 1", oERR); else n_pass++;
    $display("txn wb to idle rd=9: err=%b reg9=%h", oERR, oRS2_DATA);
  endtask

  task automatic test_reset_mid();
    logic [4:0] rds [3];
    rds[0] = 5'd1; rds[1] = 5'd2; rds[2] = 5'd4;
    for (int i = 0; i < 3; i++) begin
      idle(); iRSV_VALID = 1'b1; iRSV_RD = rds[i];
      tick();
    end
    idle(); iRS1 = 5'd1; iRS2 = 5'd2;
    #1;
    n_checks++; if (oPENDING !== m_pending()) $display("FAIL pre_rst_pending got %0d want %0d", oPENDING, m_pending()); else n_pass++;
    // Assert reset between clock edges: effect must be immediate.
    iRST_N = 1'b0;
    model_reset();
    #1;
    n_checks++; if (oPENDING !== 6'd0) $display("FAIL async_rst_pending got %0d want 0", oPENDING); else n_pass++;
    n_checks++; if (oRS1_BUSY !== 1'b0 || oRS2_BUSY !== 1'b0) $display("FAIL async_rst_busy got %b%b want 00", oRS1_BUSY, oRS2_BUSY); else n_pass++;
    n_checks++; if (oERR !== 1'b0) $display("FAIL async_rst_err got %b want 0", oERR); else n_pass++;
    // Write-backs while in reset must be ignored.
    iWB_VALID = 1'b1; iWB_RD = 5'd5; iWB_DATA = 32'hDEAD_BEEF;
    repeat (2) @(posedge iCLK);
    #1;
    idle(); iRS1 = 5'd5; iRS2 = 5'd9;
    #1;
    n_checks++; if (oRS1_DATA !== 32'h0) $display("FAIL rst_wb_ignored got %h want 0", oRS1_DATA); else n_pass++;
    n_checks++; if (oRS2_DATA !== 32'h0) $display("FAIL rst_reg9_cleared got %h want 0", oRS2_DATA); else n_pass++;
    iRST_N = 1'b1;
    // The first edge after release performs a normal update.
    iRSV_VALID = 1'b1; iRSV_RD = 5'd5;
    #1;
    n_checks++; if (oRSV_READY !== 1'b1) $display("FAIL post_rst_ready got %b want 1", oRSV_READY); else n_pass++;
    tick();
    idle();
    #1;
    n_checks++; if (oPENDING !== 6'd1) $display("FAIL post_rst_pending got %0d want 1", oPENDING); else n_pass++;
    $display("txn mid-op reset: pending after release+reserve=%0d", oPENDING);
  endtask

  task automatic test_random();
    for (int c = 0; c < 200; c++) begin
      iRS1       = 5'($urandom_range(0, 7));
      iRS2       = 5'($urandom_range(0, 7));
      iRSV_VALID = ($urandom_range(0, 99) < 50);
      iRSV_RD    = 5'($urandom_range(0, 7));
      iWB_VALID  = ($urandom_range(0, 99) < 45);
      iWB_RD     = 5'($urandom_range(0, 7));
      // Prefer write-backs to busy registers so the error flag is not the
      // only outcome exercised.
      if (iWB_VALID && !m_busy[iWB_RD]) iWB_RD = 5'($urandom_range(0, 7));
      iWB_DATA   = $urandom;
      #1;
      n_checks++; if (oRS1_DATA !== m_data(iRS1)) $display("FAIL rnd_rs1_data cyc %0d got %h want %h", c, oRS1_DATA, m_data(iRS1)); else n_pass++;
      n_checks++; if (oRS2_DATA !== m_data(iRS2)) $display("FAIL rnd_rs2_data cyc %0d got %h want %h", c, oRS2_DATA, m_data(iRS2)); else n_pass++;
      n_checks++; if (oRS1_BUSY !== m_bsy(iRS1)) $display("FAIL rnd_rs1_busy cyc %0d got %b want %b", c, oRS1_BUSY, m_bsy(iRS1)); else n_pass++;
      n_checks++; if (oRS2_BUSY !== m_bsy(iRS2)) $display("FAIL rnd_rs2_busy cyc %0d got %b want %b", c, oRS2_BUSY, m_bsy(iRS2)); else n_pass++;
      n_checks++; if (oRSV_READY !== m_ready()) $display("FAIL rnd_ready cyc %0d got %b want %b", c, oRSV_READY, m_ready()); else n_pass++;
      n_checks++; if (oPENDING !== m_pending()) $display("FAIL rnd_pending cyc %0d got %0d want %0d", c, oPENDING, m_pending()); else n_pass++;
      n_checks++; if (oERR !== m_err) $display("FAIL rnd_err cyc %0d got %b want %b", c, oERR, m_err); else n_pass++;
      $display("txn rnd %0d: rsv=%b/%0d wb=%b/%0d/%h rdy=%b pend=%0d err=%b",
               c, iRSV_VALID, iRSV_RD, iWB_VALID, iWB_RD, iWB_DATA, oRSV_READY, oPENDING, oERR);
      tick();
    end
  endtask

  initial begin
    test_reset();
    tick();
    test_reserve_bypass();
    test_waw();
    test_x0();
    test_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of each register.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (5-bit index).
REQ-003 SHALL have port iCLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port iRST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports iRS1 and iRS2  input  5  read indices for the two ALU operands.
REQ-006 SHALL have ports oRS1_DATA and oRS2_DATA  output  XLEN  operand values for iALU_IN1 and iALU_IN2.
REQ-007 SHALL have ports oRS1_BUSY and oRS2_BUSY  output  1  operand not yet available.
REQ-008 SHALL have ports iRSV_VALID  input  1 and iRSV_RD  input  5  request to reserve a destination at issue.
REQ-009 SHALL have port oRSV_READY  output  1  reservation accepted this cycle.
REQ-010 SHALL have ports iWB_VALID  input  1, iWB_RD  input  5, iWB_DATA  input  XLEN  ALU result write-back.
REQ-011 SHALL have port oPENDING  output  6  count of reserved, not-yet-written registers.
REQ-012 SHALL have port oERR  output  1  sticky protocol-error flag.

Function
REQ-013 SHALL hold NREG x XLEN registers plus a NREG-bit busy vector.
REQ-014 Register x0 SHALL always read 0, never set busy, and ignore writes.
REQ-015 Reads SHALL be combinational: oRSn_DATA = iWB_DATA when iWB_VALID, iWB_RD==iRSn, iRSn!=0; else the stored value.
REQ-016 oRSn_BUSY SHALL be busy[iRSn] and not (iWB_VALID and iWB_RD==iRSn), so a same-cycle write-back clears the stall.
REQ-017 A write with iWB_VALID=1 and iWB_RD!=0 SHALL update the register at the next rising edge.
REQ-018 At the same edge, the write SHALL clear busy[iWB_RD] and decrement oPENDING when the bit was set.
REQ-019 oRSV_READY SHALL be 1 when iRSV_VALID=1 and either iRSV_RD==0 or busy[iRSV_RD]=0 or (iWB_VALID and iWB_RD==iRSV_RD); otherwise 0 (WAW stall).
REQ-020 An accepted reservation with iRSV_RD!=0 SHALL set busy[iRSV_RD] at the next edge and increment oPENDING.
REQ-021 When a reservation and a write-back target the same rd in one cycle, the data SHALL be written, busy SHALL remain 1 and oPENDING SHALL be unchanged.
REQ-022 When a reservation and a write-back target different rds in one cycle, both SHALL take effect and oPENDING SHALL be unchanged.
REQ-023 A write-back to a register with busy=0 (x0 excluded) SHALL still write the data and SHALL set oERR.
REQ-024 oERR SHALL remain set until reset.
REQ-025 oPENDING SHALL always equal the population count of the busy vector (range 0..31) and SHALL never wrap.
REQ-026 The block SHALL have zero-cycle read latency and one-cycle write-to-array latency.
REQ-027 The block SHALL add no further pipelining.

Reset
REQ-028 iRST_N=0 SHALL immediately, without waiting for a clock edge, clear all registers to 0, the busy vector to 0, oPENDING to 0 and oERR to 0.
REQ-029 Reset asserted mid-operation SHALL discard all pending reservations; write-backs during reset SHALL be ignored.
REQ-030 After reset, oRSV_READY SHALL still follow REQ-019 combinationally.
REQ-031 The first edge with iRST_N=1 SHALL perform normal updates.

Verification
REQ-032 Reset, then iRS1=5, iRS2=0 -> oRS1_DATA=0, oRS2_DATA=0, both BUSY=0, oPENDING=0, oERR=0.
REQ-033 Reserve rd=3, then next cycle iRS1=3 -> oRS1_BUSY=1, oPENDING=1.
REQ-034 Then write-back rd=3 data 0x0000_00AB with iRS1=3 -> oRS1_BUSY=0 and oRS1_DATA=0xAB in that cycle (bypass).
REQ-035 The cycle after the REQ-034 write-back -> oPENDING=0 and the stored value is 0xAB.
REQ-036 Rd=7 busy, request reserve rd=7 without write-back -> oRSV_READY=0.
REQ-037 Same cycle as REQ-036, write-back rd=7 data 0x1234 -> oRSV_READY=1; next cycle busy[7]=1, oPENDING=1, stored 0x1234.
REQ-038 Write-back rd=0 data 0xFFFF_FFFF -> x0 reads 0, oERR stays 0.
REQ-039 Write-back rd=9 data 0x55 while busy[9]=0 -> next cycle oERR=1 and reg9=0x55.
REQ-040 Reserve rd=1,2,4 over 3 cycles, assert iRST_N=0 between clock edges -> oPENDING=0 and all BUSY=0 immediately.
